simpson_sched: RTL and testbench

// - Sequences ONE shared polynomial evaluator (func_value wrapped with a req/ack/valid handshake) to compute
//   the integer Simpson integral of f(x)=c0+c1*x+c2*x^2+c3*x^3 over [a,b], x stepping by 1.
// - Sits between the switch-input FSM (operand capture) and the display path; replaces three parallel evaluators.

---
 rtl/simpson_pkg.sv | 38 +++
 rtl/simpson_div3.sv | 34 +++
 rtl/simpson_sched.sv | 168 ++++++++++++++++
 tb/tb_simpson_sched.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/simpson_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | simpson_pkg : shared width, state encoding and group sizes            |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package simpson_pkg;

  localparam int C_W = 16;

  localparam logic [3:0] C_ST_IDLE   = 4'd0;
  localparam logic [3:0] C_ST_CHECK  = 4'd1;
  localparam logic [3:0] C_ST_PARITY = 4'd2;
  localparam logic [3:0] C_ST_REQ    = 4'd3;
  localparam logic [3:0] C_ST_WAIT   = 4'd4;
  localparam logic [3:0] C_ST_TRAP   = 4'd5;
  localparam logic [3:0] C_ST_LOOP   = 4'd6;
  localparam logic [3:0] C_ST_ADD    = 4'd7;
  localparam logic [3:0] C_ST_FIN    = 4'd8;
  localparam logic [3:0] C_ST_ERR    = 4'd9;

  typedef enum logic [3:0] {
    ST_IDLE   = C_ST_IDLE,
    ST_CHECK  = C_ST_CHECK,
    ST_PARITY = C_ST_PARITY,
    ST_REQ    = C_ST_REQ,
    ST_WAIT   = C_ST_WAIT,
    ST_TRAP   = C_ST_TRAP,
    ST_LOOP   = C_ST_LOOP,
    ST_ADD    = C_ST_ADD,
    ST_FIN    = C_ST_FIN,
    ST_ERR    = C_ST_ERR
  } state_t;

  localparam logic [1:0] C_PTS_TRAP = 2'd2;
  localparam logic [1:0] C_PTS_SIMP = 2'd3;

endpackage
`default_nettype wire

// File: rtl/simpson_div3.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | simpson_div3 : combinational unsigned (W+3)-bit divide by 3, W-bit q   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module simpson_div3 #(
  parameter int W = 16
) (
  input  logic [W+2:0] dividend,
  output logic [W-1:0] quotient
);

  logic [2:0]   w_rem;
  logic [W-1:0] w_q;

  // Restoring long division; quotient bits above W fall off the shift register.
  always_comb begin
    w_rem = '0;
    w_q   = '0;
    for (int i = W + 2; i >= 0; i--) begin
      w_rem = {w_rem[1:0], dividend[i]};
      if (w_rem >= 3'd3) begin
        w_rem = w_rem - 3'd3;
        w_q   = {w_q[W-2:0], 1'b1};
      end else begin
        w_q   = {w_q[W-2:0], 1'b0};
      end
    end
  end

  assign quotient = w_q;

endmodule
`default_nettype wire

// File: rtl/simpson_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | simpson_sched : Simpson integral sequencer over one shared evaluator   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module simpson_sched
  import simpson_pkg::*;
#(
  parameter int W = C_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   c0,
  input  logic [W-1:0]   c1,
  input  logic [W-1:0]   c2,
  input  logic [W-1:0]   c3,
  input  logic [W-1:0]   lim_a,
  input  logic [W-1:0]   lim_b,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [W-1:0]   result,
  output logic           ev_req,
  output logic [W-1:0]   ev_x,
  output logic [4*W-1:0] ev_coef,
  input  logic           ev_ack,
  input  logic           ev_valid,
  input  logic [W-1:0]   ev_value
);

  state_t         r_state, w_state_nxt;
  logic [W-1:0]   r_a, r_b, r_acc, r_result;
  logic [W-1:0]   r_f0, r_f1, r_f2;
  logic [4*W-1:0] r_coef;
  logic [1:0]     r_pt;
  logic           r_trap, r_busy, r_done, r_err;

  logic           w_last, w_capture, w_more;
  logic [W-1:0]   w_base, w_trap_avg, w_simp_q;
  logic [W+2:0]   w_simp_sum;

  assign w_last    = (r_pt == ((r_trap ? C_PTS_TRAP : C_PTS_SIMP) - 2'd1));
  assign w_capture = ((r_state == ST_REQ) && ev_ack && ev_valid) ||
                     ((r_state == ST_WAIT) && ev_valid);
  assign w_more    = (r_b > r_a);
  assign w_base    = r_trap ? (r_b - {{(W-1){1'b0}}, 1'b1}) : r_a;

  assign w_trap_avg = W'(({1'b0, r_f0} + {1'b0, r_f1}) >> 1);
  assign w_simp_sum = {3'b000, r_f0} + {1'b0, r_f1, 2'b00} + {3'b000, r_f2};

  simpson_div3 #(.W(W)) u_div3 (
    .dividend (w_simp_sum),
    .quotient (w_simp_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_state_nxt = ST_CHECK;
      ST_CHECK:  w_state_nxt = (r_a >= r_b) ? ST_ERR : ST_PARITY;
      ST_PARITY: w_state_nxt = (r_a[0] ^ r_b[0]) ? ST_REQ : ST_LOOP;
      ST_REQ: begin
        if (ev_ack) begin
          if (!ev_valid)   w_state_nxt = ST_WAIT;
          else if (w_last) w_state_nxt = r_trap ? ST_TRAP : ST_ADD;
        end
      end
      ST_WAIT: begin
        if (ev_valid) w_state_nxt = w_last ? (r_trap ? ST_TRAP : ST_ADD) : ST_REQ;
      end
      ST_TRAP:   w_state_nxt = ST_LOOP;
      ST_LOOP:   w_state_nxt = w_more ? ST_REQ : ST_FIN;
      ST_ADD:    w_state_nxt = ST_LOOP;
      ST_FIN:    w_state_nxt = ST_IDLE;
      ST_ERR:    w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_coef   <= '0;
      r_acc    <= '0;
      r_f0     <= '0;
      r_f1     <= '0;
      r_f2     <= '0;
      r_pt     <= '0;
      r_trap   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a    <= lim_a;
            r_b    <= lim_b;
            r_coef <= {c3, c2, c1, c0};
            r_acc  <= '0;
            r_busy <= 1'b1;
          end
        end
        ST_PARITY: begin
          r_pt   <= '0;
          r_trap <= r_a[0] ^ r_b[0];
        end
        ST_LOOP: begin
          r_pt   <= '0;
          r_trap <= 1'b0;
        end
        ST_TRAP: begin
          r_acc <= r_acc + w_trap_avg;
          r_b   <= r_b - {{(W-1){1'b0}}, 1'b1};
        end
        ST_ADD: begin
          r_acc <= r_acc + w_simp_q;
          r_a   <= r_a + {{(W-2){1'b0}}, 2'd2};
        end
        ST_FIN: begin
          r_result <= r_acc;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
        end
        ST_ERR: begin
          r_done <= 1'b1;
          r_err  <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase

      // Same-cycle ack+valid lands here directly from REQ.
      if (w_capture) begin
        case (r_pt)
          2'd0:    r_f0 <= ev_value;
          2'd1:    r_f1 <= ev_value;
          default: r_f2 <= ev_value;
        endcase
        if (!w_last) r_pt <= r_pt + 2'd1;
      end
    end
  end

  always_comb begin
    ev_x = '0;
    if (r_state == ST_REQ) ev_x = w_base + {{(W-2){1'b0}}, r_pt};
  end

  assign ev_req  = (r_state == ST_REQ);
  assign ev_coef = r_coef;
  assign busy    = r_busy;
  assign done    = r_done;
  assign err     = r_err;
  assign result  = r_result;

endmodule
`default_nettype wire

// File: tb/tb_simpson_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_simpson_sched : directed bench with evaluator and integral model    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_simpson_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] c0 = '0, c1 = '0, c2 = '0, c3 = '0, lim_a = '0, lim_b = '0;
  logic        busy, done, err, ev_req;
  logic [15:0] result, ev_x;
  logic [63:0] ev_coef;
  logic        ev_ack = 1'b0, ev_valid = 1'b0;
  logic [15:0] ev_value = '0;

  int          n_pass = 0;
  int          n_total = 0;

  logic [15:0] model_result = '0;
  logic [15:0] exp_res = '0;
  bit          exp_err = 1'b0;
  logic [63:0] exp_coef = '0;
  logic [15:0] exp_xq[$];
  int          amax = 0, vmin = 0, vmax = 0;
  bit          pend = 1'b0, stray = 1'b0, chk_en = 1'b0;

  simpson_sched #(.W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .c0(c0), .c1(c1), .c2(c2), .c3(c3), .lim_a(lim_a), .lim_b(lim_b),
    .busy(busy), .done(done), .err(err), .result(result),
    .ev_req(ev_req), .ev_x(ev_x), .ev_coef(ev_coef),
    .ev_ack(ev_ack), .ev_valid(ev_valid), .ev_value(ev_value)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, got, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [15:0] fval(input logic [63:0] cf, input int x);
    logic [15:0] xx;
    xx = x[15:0];
    return cf[15:0] + cf[31:16] * xx + cf[47:32] * xx * xx + cf[63:48] * xx * xx * xx;
  endfunction

  // Integral from the rules: trapezoid on a trailing odd interval, Simpson on pairs.
  function automatic logic [15:0] golden(input logic [63:0] cf, input logic [15:0] a, input logic [15:0] b);
    longint acc;
    int     lo, hi;
    acc = 0;
    lo  = int'(a);
    hi  = int'(b);
    if ((hi - lo) % 2 == 1) begin
      acc += (longint'(fval(cf, hi - 1)) + longint'(fval(cf, hi))) / 2;
      hi--;
    end
    for (int x = lo; x < hi; x += 2)
      acc += (longint'(fval(cf, x)) + 4 * longint'(fval(cf, x + 1)) + longint'(fval(cf, x + 2))) / 3;
    return acc[15:0];
  endfunction

  task automatic launch(input logic [15:0] k0, k1, k2, k3, a, b);
    int lo, hi;
    exp_coef = {k3, k2, k1, k0};
    exp_err  = (a >= b);
    exp_res  = golden(exp_coef, a, b);
    exp_xq.delete();
    if (!exp_err) begin
      lo = int'(a);
      hi = int'(b);
      if ((hi - lo) % 2 == 1) begin
        exp_xq.push_back(16'(hi - 1));
        exp_xq.push_back(16'(hi));
        hi--;
      end
      for (int x = lo; x < hi; x += 2) begin
        exp_xq.push_back(16'(x));
        exp_xq.push_back(16'(x + 1));
        exp_xq.push_back(16'(x + 2));
      end
    end
    c0 = k0; c1 = k1; c2 = k2; c3 = k3; lim_a = a; lim_b = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 3000) begin
      tick();
      lat++;
    end
    check("done_seen", done, 1);
    check("points_all_requested", exp_xq.size(), 0);
    tick();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_ev_req"}, ev_req, 0);
    check({tag, "_ev_x"}, ev_x, 0);
    check({tag, "_ev_coef"}, ev_coef, 0);
  endtask

  // Evaluator: random ack delay, random valid delay after ack, values from ev_coef.
  initial begin : evaluator
    int          acnt, vcnt, vd;
    bit          req_seen;
    logic [15:0] req_x, pval;
    acnt = 0; vcnt = 0; req_seen = 1'b0; req_x = '0; pval = '0;
    forever begin
      @(negedge clk);
      ev_ack   = 1'b0;
      ev_valid = 1'b0;
      if (!rst_n) begin
        pend     = 1'b0;
        req_seen = 1'b0;
      end else if (stray) begin
        ev_valid = 1'b1;
        ev_value = 16'hBEEF;
        stray    = 1'b0;
      end else if (pend) begin
        check("single_outstanding", ev_req, 0);
        vcnt--;
        if (vcnt == 0) begin
          ev_valid = 1'b1;
          ev_value = pval;
          pend     = 1'b0;
        end
      end else if (ev_req) begin
        if (!req_seen) begin
          req_seen = 1'b1;
          req_x    = ev_x;
          acnt     = int'($urandom_range(amax, 0));
        end else begin
          check("ev_x_stable", ev_x, req_x);
        end
        if (acnt == 0) begin
          ev_ack   = 1'b1;
          req_seen = 1'b0;
          if (exp_xq.size() == 0) check("ev_req_expected", exp_xq.size(), 1);
          else check("ev_x_seq", ev_x, exp_xq.pop_front());
          pval = fval(ev_coef, int'(ev_x));
          vd   = int'($urandom_range(vmax, vmin));
          if (vd == 0) begin
            ev_valid = 1'b1;
            ev_value = pval;
          end else begin
            pend = 1'b1;
            vcnt = vd;
          end
        end else begin
          acnt--;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin : compare
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && chk_en) begin
        if (done) begin
          check("err_flag", err, exp_err);
          check("busy_low_at_done", busy, 0);
          if (!exp_err) model_result = exp_res;
        end
        if (err) check("err_with_done", done, 1);
        check("result", result, model_result);
        if (busy) check("ev_coef", ev_coef, exp_coef);
      end
    end
  end

  initial begin : main
    int lat;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    check_idle("reset");
    chk_en = 1'b1;

    check("pin_square_0_2", golden(64'h0000_0001_0000_0000, 16'd0, 16'd2), 2);
    check("pin_linear_0_3", golden(64'h0000_0000_0001_0000, 16'd0, 16'd3), 4);
    check("pin_const_0_4",  golden(64'h0000_0000_0000_0001, 16'd0, 16'd4), 4);
    check("pin_cube_0_2",   golden(64'h0001_0000_0000_0000, 16'd0, 16'd2), 4);

    launch(16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 16'd2);
    wait_done(lat);
    check("case_square_result", result, 2);

    launch(16'd0, 16'd1, 16'd0, 16'd0, 16'd0, 16'd3);
    wait_done(lat);
    check("case_linear_result", result, 4);

    launch(16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd4);
    wait_done(lat);
    check("case_const_result", result, 4);

    launch(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd5);
    wait_done(lat);
    check("err_equal_latency", lat, 3);
    check("err_equal_result_held", result, 4);

    launch(16'd9, 16'd9, 16'd9, 16'd9, 16'd7, 16'd3);
    wait_done(lat);
    check("err_reverse_latency", lat, 3);
    check("err_reverse_result_held", result, 4);

    amax = 5; vmin = 0; vmax = 7;
    for (int r = 0; r < 3; r++) begin
      launch(16'd0, 16'd1, 16'd0, 16'd0, 16'd0, 16'd3);
      tick();
      tick();
      c0 = 16'h1234; lim_a = 16'd0; lim_b = 16'd9;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(lat);
      check("backpressure_result", result, 4);
    end

    launch(16'd3, 16'd0, 16'd0, 16'd1, 16'd1, 16'd6);
    wait_done(lat);
    check("cubic_result", result, golden(exp_coef, 16'd1, 16'd6));

    amax = 0; vmin = 6; vmax = 6;
    launch(16'd0, 16'd1, 16'd0, 16'd0, 16'd0, 16'd3);
    for (int i = 0; i < 50 && !pend; i++) tick();
    check("reached_wait", pend, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_xq.delete();
    model_result = '0;
    exp_coef = '0;
    stray = 1'b1;
    tick();
    check_idle("midrun_reset");
    tick();
    check_idle("after_stray");

    vmin = 0; vmax = 0;
    launch(16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 16'd2);
    wait_done(lat);
    check("restart_result", result, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
